fifo_wr_arbiter: RTL

//   Round-robin write arbiter that shares one FIFO_Depth instance among num_req writers.

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among num_req producers.
// Optional ARB_STATS_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int data_depth = 32,
  parameter int fifo_depth = 8,
  parameter int num_req    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_req-1:0]              req,
  input  logic [num_req*data_depth-1:0]   req_data,
  input  logic                            fifo_rd,
  input  logic                            fifo_f,
  output logic [num_req-1:0]              gnt,
  output logic                            fifo_cs,
  output logic                            fifo_wr_enb,
  output logic [data_depth-1:0]           fifo_data_in,
`ifdef ARB_STATS_EN
  output logic [15:0]                     stall_cnt,
`endif
  output logic [$clog2(fifo_depth+1)-1:0] count
);
  localparam int CW = $clog2(fifo_depth+1);
  localparam int PW = $clog2(num_req);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [num_req-1:0]      gnt_q, gnt_d;
  logic                    cs_q, cs_d, wr_q, wr_d;
  logic [data_depth-1:0]   data_q, data_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           ptr_q, ptr_d;

  logic [num_req-1:0][data_depth-1:0] word;
  logic [PW-1:0]           win, idx;
  logic                    found, grant_ok, inc, dec;
  int unsigned             rr_sum;

  for (genvar g = 0; g < num_req; g++) begin : g_unpack
    assign word[g] = req_data[g*data_depth +: data_depth];
  end

  // First requester at or after ptr, wrapping modulo num_req.
  always_comb begin
    win    = '0;
    idx    = '0;
    found  = 1'b0;
    rr_sum = 0;
    for (int k = 0; k < num_req; k++) begin
      rr_sum = int'(ptr_q) + k;
      if (rr_sum >= num_req) rr_sum = rr_sum - num_req;
      idx = PW'(rr_sum);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign grant_ok = (|req) && (count_q < CW'(fifo_depth)) && !fifo_f;
  assign inc      = (state_q == WRITE);
  assign dec      = fifo_rd && (count_q != '0);

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (grant_ok) begin
        state_d    = WRITE;
        gnt_d[win] = 1'b1;
        cs_d       = 1'b1;
        wr_d       = 1'b1;
        data_d     = word[win];
        ptr_d      = (win == PW'(num_req-1)) ? '0 : win + PW'(1);
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Concurrent write-close and read cancel out.
  always_comb begin
    count_d = count_q;
    case ({inc, dec})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_cs      = cs_q;
  assign fifo_wr_enb  = wr_q;
  assign fifo_data_in = data_q;
  assign count        = count_q;

`ifdef ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // A pending request in IDLE that cannot win is a stall.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && (|req) && !grant_ok && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
